com_bus_arbiter: RTL and testbench
==================================

// Module: com_bus_arbiter
// PURPOSE
//  Arbitrates the shared coherence bus (Address_Com / Data_Bus_Com / Data_in_Bus) among the four
//  cache wrappers of the 4-core MESI system. Each wrapper raises a processor-side request (miss,
//  upgrade) and a snoop-side request (flush / data supply); one requester owns the bus at a time.
//  Snoop requests outrank processor requests; round-robin within each class; watchdog on hold time.
// PARAMETERS
//  NUM_CORES   4    number of cache wrappers (requesters per class)
//  MAX_HOLD    64   max consecutive cycles one grant may be held before forced release
//  CNT_W       7    width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk                 in   1          single clock, all logic on rising edge
//  rst_n               in   1          synchronous, active-low reset
//  Com_Bus_Req_proc    in   NUM_CORES  per-core processor-side bus request, level, held while owning
//  Com_Bus_Req_snoop   in   NUM_CORES  per-core snoop-side bus request, level, held while owning
//  Com_Bus_Gnt_proc    out  NUM_CORES  per-core processor grant, registered, one-hot or zero
//  Com_Bus_Gnt_snoop   out  NUM_CORES  per-core snoop grant, registered, one-hot or zero
//  Bus_Busy            out  1          1 while any grant is asserted
//  Gnt_timeout         out  1          1-cycle pulse when a grant is revoked by the watchdog
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): all grants 0, Bus_Busy 0, Gnt_timeout 0, state IDLE, hold count 0,
//    both round-robin pointers = 0. Reset mid-grant revokes the grant on that same edge.
//  - Invariant: at most one bit set across {Com_Bus_Gnt_snoop, Com_Bus_Gnt_proc} combined.
//  - States: IDLE (no owner), GRANT (owner holds bus), TURN (one dead cycle, all grants 0).
//  - Arbitration (evaluated at edges leaving IDLE or TURN): if any snoop req, pick snoop winner by
//    round-robin from snoop_ptr; else if any proc req, pick proc winner from proc_ptr; else go/stay
//    IDLE. Winner's grant is set on that edge; state -> GRANT; the class pointer <= (winner+1) mod
//    NUM_CORES. Other class pointer unchanged.
//  - Latency: request rising at edge E in IDLE -> grant high after E (visible next cycle).
//  - GRANT: owner keeps grant while its own request stays 1; no preemption, even by snoop reqs.
//    Owner's request sampled 0 -> clear grant, state TURN. Requests of non-owners ignored here.
//  - Hold counter: cleared on grant, +1 each GRANT cycle. If owner still requesting when count
//    reaches MAX_HOLD-1: clear grant, pulse Gnt_timeout for one cycle, state TURN. Owner's request
//    then competes normally; it is not re-granted ahead of others (pointer already past it).
//  - TURN lasts exactly one cycle; arbitration at its end edge, so back-to-back owners are always
//    separated by one cycle with no grant (bus driver turnaround).
//  - Core requesting both proc and snoop: snoop wins; proc request waits.
//  - A request dropped before being granted is simply not considered; no latching of requests.
//  - Bus_Busy = OR of all grant bits (registered alongside grants).
// STRUCTURE
//  - Shared package/defines file: NUM_CORES, state encoding (IDLE/GRANT/TURN), MAX_HOLD default.
//  - Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> one-hot winner,
//    index, valid); instantiated twice (snoop class, proc class). FSM, counter, pointers in top.
// TESTING
//  - Reset: hold rst_n=0 with all reqs=4'b1111 -> all grants 0, Bus_Busy 0; release -> snoop core0
//    granted one cycle after first rst_n=1 edge.
//  - Single proc: Req_proc=4'b0100 for 5 cycles then 0 -> Gnt_proc=4'b0100 cycles 1..5, 0 after,
//    one TURN cycle, then IDLE; Bus_Busy tracks grant.
//  - Round robin: Req_proc=4'b1111, each owner drops req after 2 granted cycles and re-raises ->
//    grant order core0,1,2,3,0 with one dead cycle between each.
//  - Snoop priority: core1 owns proc grant, Req_snoop=4'b1000 and Req_proc=4'b0001 raised -> no
//    preemption; after core1 drops, TURN, then Gnt_snoop=4'b1000 before core0 proc.
//  - Watchdog: MAX_HOLD=8, core2 proc req stuck high -> grant 8 cycles, Gnt_timeout pulse 1 cycle,
//    TURN; with Req_proc=4'b0101 also pending, core0 granted next, not core2.
//  - Invariant check on every cycle of random stimulus: grant bits combined are one-hot or zero.

Source files
------------

// File: rtl/com_bus_arbiter_pkg.sv
// Shared constants and state encoding for the coherence bus arbiter.
// Parameter defaults for the arbiter are taken from here so all files agree on one value.
package com_bus_arbiter_pkg;

    localparam int NUM_CORES = 4;
    localparam int MAX_HOLD  = 64;
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
// The search wraps around, so every requester is reachable from any pointer value.
module com_bus_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = IW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Coherence bus arbiter: snoop requests outrank processor requests, round-robin within each
// class, one dead cycle between owners, and a watchdog that revokes an over-long grant.
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES = com_bus_arbiter_pkg::NUM_CORES,
    parameter int MAX_HOLD  = com_bus_arbiter_pkg::MAX_HOLD,
    parameter int CNT_W     = com_bus_arbiter_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_proc,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
    output logic                 Bus_Busy,
    output logic                 Gnt_timeout
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // Requests are levels held for as long as the core wants the bus; a grant is registered and
    // stays up until the owner's request is sampled low or the watchdog fires.
    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]        snoop_ptr_q, snoop_ptr_d;
    logic [PW-1:0]        proc_ptr_q, proc_ptr_d;
    logic [NUM_CORES-1:0] gnt_proc_q, gnt_proc_d;
    logic [NUM_CORES-1:0] gnt_snoop_q, gnt_snoop_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_CORES-1:0] snoop_win, proc_win;
    logic [PW-1:0]        snoop_idx, proc_idx;
    logic                 snoop_valid, proc_valid;
    logic                 owner_req;

    com_bus_arbiter_rr_pick #(.N(NUM_CORES), .IW(PW)) u_pick_snoop (
        .req   (Com_Bus_Req_snoop),
        .ptr   (snoop_ptr_q),
        .gnt   (snoop_win),
        .idx   (snoop_idx),
        .valid (snoop_valid)
    );

    com_bus_arbiter_rr_pick #(.N(NUM_CORES), .IW(PW)) u_pick_proc (
        .req   (Com_Bus_Req_proc),
        .ptr   (proc_ptr_q),
        .gnt   (proc_win),
        .idx   (proc_idx),
        .valid (proc_valid)
    );

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_CORES - 1)) ? '0 : idx + PW'(1);
    endfunction

    assign owner_req = |((gnt_proc_q & Com_Bus_Req_proc) | (gnt_snoop_q & Com_Bus_Req_snoop));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snoop_ptr_d = snoop_ptr_q;
        proc_ptr_d  = proc_ptr_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_GRANT: begin
                if (!owner_req || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    gnt_proc_d  = '0;
                    gnt_snoop_d = '0;
                    timeout_d   = owner_req;
                    state_d     = ST_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
                if (snoop_valid) begin
                    gnt_snoop_d = snoop_win;
                    snoop_ptr_d = ptr_after(snoop_idx);
                    state_d     = ST_GRANT;
                end else if (proc_valid) begin
                    gnt_proc_d = proc_win;
                    proc_ptr_d = ptr_after(proc_idx);
                    state_d    = ST_GRANT;
                end
            end
        endcase
        busy_d = (|gnt_proc_d) | (|gnt_snoop_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            snoop_ptr_q <= '0;
            proc_ptr_q  <= '0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snoop_ptr_q <= snoop_ptr_d;
            proc_ptr_q  <= proc_ptr_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_q;
    assign Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign Bus_Busy          = busy_q;
    assign Gnt_timeout       = timeout_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed bench for com_bus_arbiter built with a short watchdog (MAX_HOLD = 8).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_com_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_proc = 4'b0000;
    logic [3:0] req_snoop = 4'b0000;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       bus_busy;
    logic       gnt_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    com_bus_arbiter #(.NUM_CORES(4), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Bus_Busy          (bus_busy),
        .Gnt_timeout       (gnt_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_proc = 4'b0000;
        req_snoop = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_proc = 4'b1111;
        req_snoop = 4'b1111;
        step();
        step();
        tests_run++;
        if ({gnt_snoop, gnt_proc, bus_busy, gnt_timeout} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: snoop=%b proc=%b busy=%b to=%b, want all 0",
                     gnt_snoop, gnt_proc, bus_busy, gnt_timeout);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (gnt_snoop !== 4'b0001 || gnt_proc !== 4'b0000 || bus_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: snoop=%b proc=%b busy=%b, want 0001 0000 1",
                     gnt_snoop, gnt_proc, bus_busy);
        end
    endtask

    task automatic test_single_proc();
        do_reset();
        req_proc = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            step();
            tests_run++;
            if (gnt_proc !== 4'b0100 || gnt_snoop !== 4'b0000 || bus_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_proc_cyc%0d: proc=%b snoop=%b busy=%b, want 0100 0000 1",
                         c, gnt_proc, gnt_snoop, bus_busy);
            end
        end
        req_proc = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            tests_run++;
            if (gnt_proc !== 4'b0000 || bus_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_proc_release%0d: proc=%b busy=%b, want 0000 0",
                         c, gnt_proc, bus_busy);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        req_proc = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            step();
            step();
            tests_run++;
            if (gnt_proc !== exp || gnt_snoop !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_owner%0d: proc=%b snoop=%b, want %b 0000",
                         k, gnt_proc, gnt_snoop, exp);
            end
            req_proc = 4'b1111 & ~exp;
            step();
            tests_run++;
            if (gnt_proc !== 4'b0000 || bus_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_turn%0d: proc=%b busy=%b, want 0000 0", k, gnt_proc, bus_busy);
            end
            req_proc = 4'b1111;
        end
        req_proc = 4'b0000;
    endtask

    task automatic test_snoop_priority();
        do_reset();
        req_proc = 4'b0010;
        step();
        req_snoop = 4'b1000;
        req_proc = 4'b0011;
        step();
        step();
        tests_run++;
        if (gnt_proc !== 4'b0010 || gnt_snoop !== 4'b0000) begin
            tests_failed++;
            $display("FAIL snoop_no_preempt: proc=%b snoop=%b, want 0010 0000", gnt_proc, gnt_snoop);
        end
        req_proc = 4'b0001;
        step();
        tests_run++;
        if (gnt_proc !== 4'b0000 || gnt_snoop !== 4'b0000) begin
            tests_failed++;
            $display("FAIL snoop_turn: proc=%b snoop=%b, want 0000 0000", gnt_proc, gnt_snoop);
        end
        step();
        tests_run++;
        if (gnt_snoop !== 4'b1000 || gnt_proc !== 4'b0000) begin
            tests_failed++;
            $display("FAIL snoop_wins: snoop=%b proc=%b, want 1000 0000", gnt_snoop, gnt_proc);
        end
        req_snoop = 4'b0000;
        step();
        step();
        tests_run++;
        if (gnt_proc !== 4'b0001 || gnt_snoop !== 4'b0000) begin
            tests_failed++;
            $display("FAIL snoop_then_proc: proc=%b snoop=%b, want 0001 0000", gnt_proc, gnt_snoop);
        end
        req_proc = 4'b0000;
    endtask

    task automatic test_watchdog();
        do_reset();
        req_proc = 4'b0100;
        step();
        req_proc = 4'b0101;
        for (int c = 1; c <= 8; c++) begin
            tests_run++;
            if (gnt_proc !== 4'b0100 || gnt_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL wd_hold_cyc%0d: proc=%b to=%b, want 0100 0", c, gnt_proc, gnt_timeout);
            end
            if (c < 8) step();
        end
        step();
        tests_run++;
        if (gnt_proc !== 4'b0000 || gnt_timeout !== 1'b1 || bus_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_revoke: proc=%b to=%b busy=%b, want 0000 1 0",
                     gnt_proc, gnt_timeout, bus_busy);
        end
        step();
        tests_run++;
        if (gnt_proc !== 4'b0001 || gnt_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_next_owner: proc=%b to=%b, want 0001 0", gnt_proc, gnt_timeout);
        end
        rst_n = 1'b0;
        step();
        tests_run++;
        if (gnt_proc !== 4'b0000 || bus_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_grant: proc=%b busy=%b, want 0000 0", gnt_proc, bus_busy);
        end
        rst_n = 1'b1;
        req_proc = 4'b0000;
    endtask

    task automatic test_random_invariant();
        logic [7:0] all_g;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req_proc = 4'($urandom_range(0, 15));
            req_snoop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step();
            all_g = {gnt_snoop, gnt_proc};
            tests_run++;
            if ((all_g & (all_g - 8'd1)) !== 8'd0 || bus_busy !== (|all_g)) begin
                tests_failed++;
                $display("FAIL rand_invariant_cyc%0d: grants=%b busy=%b", c, all_g, bus_busy);
            end
        end
        req_proc = 4'b0000;
        req_snoop = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_proc();
        test_round_robin();
        test_snoop_priority();
        test_watchdog();
        test_random_invariant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
